counter_param: RTL and testbench

COUNTER_PARAM -- requirements
Module: counter_param

---
 rtl/counter_param.sv | 121 ++++++++++++
 tb/tb_counter_param.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_param.sv
// counter_param: parameterised up/down counter with wrap or saturate at the
// 0..MAX bounds, synchronous clear and clamped parallel load.
// Optional compare-hit output is built when COUNTER_PARAM_CMP_EN is defined.
module counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 15,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_PARAM_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_hit,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam bit               SAT   = (SAT_MODE != 0);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_UP_BOUND,
    OP_DN_BOUND
  } op_e;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  op_e              w_op;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ovf_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == MAX_W);
  assign w_at_zero = (r_q == '0);

  // Decode this cycle's operation with clr > load > en priority.
  always_comb begin
    w_op = OP_HOLD;
    if (clr) begin
      w_op = OP_CLR;
    end else if (load) begin
      w_op = OP_LOAD;
    end else if (en) begin
      if (up_dn) begin
        w_op = w_at_max ? OP_UP_BOUND : OP_INC;
      end else begin
        w_op = w_at_zero ? OP_DN_BOUND : OP_DEC;
      end
    end
  end

  // Next count and overflow flag for the decoded operation.
  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = 1'b0;
    unique case (w_op)
      OP_CLR:      w_q_nxt = '0;
      OP_LOAD:     w_q_nxt = (load_val > MAX_W) ? MAX_W : load_val;
      OP_INC:      w_q_nxt = r_q + ONE_W;
      OP_DEC:      w_q_nxt = r_q - ONE_W;
      OP_UP_BOUND: begin
        w_q_nxt   = SAT ? MAX_W : '0;
        w_ovf_nxt = 1'b1;
      end
      OP_DN_BOUND: begin
        w_q_nxt   = SAT ? '0 : MAX_W;
        w_ovf_nxt = 1'b1;
      end
      default:     w_q_nxt = r_q;
    endcase
  end

  // Count and overflow registers; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign Q   = r_q;
  assign ovf = r_ovf;
  assign tc  = up_dn ? w_at_max : w_at_zero;

`ifdef COUNTER_PARAM_CMP_EN
  logic r_cmp_hit;
  logic w_update;

  // A plain hold is not an update, so a count parked on cmp_val pulses once.
  assign w_update = (w_op != OP_HOLD);

  // Compare-hit pulse, aligned with the Q value that matches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmp_hit <= 1'b0;
    end else begin
      r_cmp_hit <= w_update && (w_q_nxt == cmp_val);
    end
  end

  assign cmp_hit = r_cmp_hit;
`endif

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: four instances (wrap MAX=9, saturate MAX=9,
// MAX=0, full-range MAX=15) share stimulus; a behavioural model pushes
// expected results into a queue that each test pops after every clock.
module tb_counter_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cmp_val = '0;

  logic [3:0] q_w, q_s, q_z, q_f;
  logic       tc_w, tc_s, tc_z, tc_f;
  logic       ovf_w, ovf_s, ovf_z, ovf_f;
  logic       cmp_w, cmp_s, cmp_z, cmp_f;

  always #5 clk = ~clk;

`ifdef COUNTER_PARAM_CMP_EN
  counter_param #(.WIDTH(4), .MAX(9), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .cmp_hit(cmp_w),
    .Q(q_w), .tc(tc_w), .ovf(ovf_w));
  counter_param #(.WIDTH(4), .MAX(9), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .cmp_hit(cmp_s),
    .Q(q_s), .tc(tc_s), .ovf(ovf_s));
  counter_param #(.WIDTH(4), .MAX(0), .SAT_MODE(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .cmp_hit(cmp_z),
    .Q(q_z), .tc(tc_z), .ovf(ovf_z));
  counter_param #(.WIDTH(4), .MAX(15), .SAT_MODE(0)) u_full (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .cmp_hit(cmp_f),
    .Q(q_f), .tc(tc_f), .ovf(ovf_f));
`else
  counter_param #(.WIDTH(4), .MAX(9), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(q_w), .tc(tc_w), .ovf(ovf_w));
  counter_param #(.WIDTH(4), .MAX(9), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(q_s), .tc(tc_s), .ovf(ovf_s));
  counter_param #(.WIDTH(4), .MAX(0), .SAT_MODE(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(q_z), .tc(tc_z), .ovf(ovf_z));
  counter_param #(.WIDTH(4), .MAX(15), .SAT_MODE(0)) u_full (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(q_f), .tc(tc_f), .ovf(ovf_f));
  assign cmp_w = 1'b0;
  assign cmp_s = 1'b0;
  assign cmp_z = 1'b0;
  assign cmp_f = 1'b0;
`endif

  logic [3:0] dq   [4];
  logic       dtc  [4];
  logic       dovf [4];
  assign dq[0] = q_w;  assign dq[1] = q_s;  assign dq[2] = q_z;  assign dq[3] = q_f;
  assign dtc[0] = tc_w; assign dtc[1] = tc_s; assign dtc[2] = tc_z; assign dtc[3] = tc_f;
  assign dovf[0] = ovf_w; assign dovf[1] = ovf_s; assign dovf[2] = ovf_z; assign dovf[3] = ovf_f;

  typedef struct {
    logic [3:0] q   [4];
    logic       ovf [4];
    logic       cmp;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_max [4] = '{9, 9, 0, 15};
  bit          m_sat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0]  m_q   [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  int          n_total = 0;
  int          n_bad = 0;

  function automatic void model_next(input int i, output logic [3:0] nq, output logic no);
    int unsigned q;
    q  = int'(m_q[i]);
    nq = m_q[i];
    no = 1'b0;
    if (!rst_n) nq = '0;
    else if (clr) nq = '0;
    else if (load) nq = (int'(load_val) > m_max[i]) ? 4'(m_max[i]) : load_val;
    else if (en) begin
      if (up_dn) begin
        if (q == m_max[i]) begin
          no = 1'b1;
          if (!m_sat[i]) nq = '0;
        end else nq = 4'(q + 1);
      end else begin
        if (q == 0) begin
          no = 1'b1;
          if (!m_sat[i]) nq = 4'(m_max[i]);
        end else nq = 4'(q - 1);
      end
    end
  endfunction

  function automatic logic exp_tc(input int i);
    return up_dn ? (int'(m_q[i]) == m_max[i]) : (m_q[i] == 4'd0);
  endfunction

  // Model the coming edge, queue the expectation, then advance one clock.
  task automatic tick();
    exp_t e;
    logic [3:0] nq;
    logic no;
    e.cmp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_next(i, nq, no);
      if (i == 0)
        e.cmp = rst_n && (clr || load || en) && (nq == cmp_val);
      m_q[i]   = nq;
      e.q[i]   = nq;
      e.ovf[i] = no;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b1; load_val = 4'd5;
    for (int c = 0; c < 2; c++) begin
      tick();
      e = sb.pop_front();
      if (c == 1) begin
        for (int i = 0; i < 4; i++) begin
          n_total++;
          if (dq[i] !== 4'd0 || dq[i] !== e.q[i]) begin
            n_bad++;
            $display("FAIL reset_q inst=%0d got=%0d exp=0", i, dq[i]);
          end
          n_total++;
          if (dovf[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf inst=%0d got=%b exp=0", i, dovf[i]);
          end
        end
      end
    end
    rst_n = 1'b1; en = 1'b0; load = 1'b0;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    logic [3:0] want;
    en = 1'b1; up_dn = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      want = 4'(k % 10);
      n_total++;
      if (q_w !== want || q_w !== e.q[0]) begin
        n_bad++;
        $display("FAIL wrap_up_q step=%0d got=%0d exp=%0d", k, q_w, want);
      end
      n_total++;
      if (ovf_w !== (k == 10)) begin
        n_bad++;
        $display("FAIL wrap_up_ovf step=%0d got=%b exp=%b", k, ovf_w, (k == 10));
      end
      n_total++;
      if (tc_w !== (want == 4'd9)) begin
        n_bad++;
        $display("FAIL wrap_up_tc step=%0d got=%b exp=%b", k, tc_w, (want == 4'd9));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    exp_t e;
    logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    load = 1'b1; load_val = 4'd2;
    tick();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if (q_w !== seq[k] || ovf_w !== (k == 2) || ovf_w !== e.ovf[0]) begin
        n_bad++;
        $display("FAIL wrap_down step=%0d got=%0d/%b exp=%0d/%b", k, q_w, ovf_w, seq[k], (k == 2));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e;
    logic ovf_seq [3] = '{1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 4'd8;
    tick();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if (q_s !== 4'd9 || ovf_s !== ovf_seq[k] || q_s !== e.q[1]) begin
        n_bad++;
        $display("FAIL saturate step=%0d got=%0d/%b exp=9/%b", k, q_s, ovf_s, ovf_seq[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    exp_t e;
    clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; up_dn = 1'b1;
    tick();
    e = sb.pop_front();
    n_total++;
    if (q_w !== 4'd0 || q_f !== 4'd0) begin
      n_bad++;
      $display("FAIL priority_clr got=%0d,%0d exp=0,0", q_w, q_f);
    end
    clr = 1'b0; load_val = 4'd14;
    tick();
    e = sb.pop_front();
    n_total++;
    if (q_w !== 4'd9 || ovf_w !== 1'b0 || q_f !== 4'd14 || q_f !== e.q[3]) begin
      n_bad++;
      $display("FAIL load_clamp got=%0d/%b full=%0d exp=9/0 full=14", q_w, ovf_w, q_f);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    load = 1'b1; load_val = 4'd7;
    tick();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; rst_n = 1'b0;
    tick();
    e = sb.pop_front();
    n_total++;
    if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got=%0d/%b exp=0/0", q_w, ovf_w);
    end
    rst_n = 1'b1;
    tick();
    e = sb.pop_front();
    n_total++;
    if (q_w !== 4'd1 || q_w !== e.q[0]) begin
      n_bad++;
      $display("FAIL reset_release got=%0d exp=1", q_w);
    end
    en = 1'b0;
  endtask

  task automatic test_direction_switch();
    exp_t e;
    logic [3:0] seq [6] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd0, 4'd9};
    logic       dir [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    load = 1'b1; load_val = 4'd1;
    tick();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      up_dn = dir[k];
      #1;
      n_total++;
      if (tc_w !== exp_tc(0)) begin
        n_bad++;
        $display("FAIL dir_tc step=%0d got=%b exp=%b", k, tc_w, exp_tc(0));
      end
      tick();
      e = sb.pop_front();
      n_total++;
      if (q_w !== seq[k]) begin
        n_bad++;
        $display("FAIL dir_switch step=%0d got=%0d exp=%0d", k, q_w, seq[k]);
      end
    end
    en = 1'b0;
  endtask

`ifdef COUNTER_PARAM_CMP_EN
  task automatic test_compare();
    exp_t e;
    clr = 1'b1; cmp_val = 4'd3;
    tick();
    e = sb.pop_front();
    clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if (cmp_w !== (k == 3) || cmp_w !== e.cmp) begin
        n_bad++;
        $display("FAIL cmp_count step=%0d got=%b exp=%b", k, cmp_w, (k == 3));
      end
    end
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    tick();
    e = sb.pop_front();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if (cmp_w !== 1'b0 || q_w !== 4'd3) begin
        n_bad++;
        $display("FAIL cmp_hold step=%0d got=%b q=%0d exp=0 q=3", k, cmp_w, q_w);
      end
    end
  endtask
`endif

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 300; c++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0) ^ (c >= 150);
      load_val = 4'($urandom_range(0, 15));
      cmp_val  = 4'($urandom_range(0, 9));
      #1;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (dtc[i] !== exp_tc(i)) begin
          n_bad++;
          $display("FAIL rand_tc cyc=%0d inst=%0d got=%b exp=%b", c, i, dtc[i], exp_tc(i));
        end
      end
      tick();
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (dq[i] !== e.q[i] || dovf[i] !== e.ovf[i] || int'(dq[i]) > m_max[i]) begin
          n_bad++;
          $display("FAIL rand_q cyc=%0d inst=%0d got=%0d/%b exp=%0d/%b",
                   c, i, dq[i], dovf[i], e.q[i], e.ovf[i]);
        end
      end
`ifdef COUNTER_PARAM_CMP_EN
      n_total++;
      if (cmp_w !== e.cmp) begin
        n_bad++;
        $display("FAIL rand_cmp cyc=%0d got=%b exp=%b", c, cmp_w, e.cmp);
      end
`endif
    end
    rst_n = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "test done: total=%0d bad=%0d", n_total, n_bad);
  end

  initial begin
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_direction_switch();
`ifdef COUNTER_PARAM_CMP_EN
    test_compare();
`endif
    test_random();
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
